// File: rtl/useq_ctrl.sv
// Sequenced instruction controller: accepts one instruction per handshake, classifies it
// and steps a small FSM that drives register file, ALU, shared bus and RAM control.
module useq_ctrl #(
  parameter int DATA_W  = 4,
  parameter int OPC_W   = 4,
  parameter int OPR_W   = 4,
  parameter int CTRL_W  = 4,
  parameter int TIMEOUT = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [OPC_W+OPR_W-1:0] instr,
  input  logic                   instr_valid,
  output logic                   instr_ready,
  input  logic                   mem_ack,
  inout  wire  [DATA_W-1:0]      bus,
  output logic                   bus_oe,
  output logic [CTRL_W-1:0]      instr_r,
  output logic [CTRL_W-1:0]      instr_a,
  output logic                   reg_we,
  output logic                   reg_oe,
  output logic                   alu_en,
  output logic                   mem_req,
  output logic                   mem_we,
  output logic [OPR_W-1:0]       mem_addr,
  output logic                   done,
  output logic                   err
);

  // state  | meaning
  // IDLE   | waiting for an instruction, instr_ready high
  // EXEC   | ALU/REG single cycle, or first IMM cycle (bus driven)
  // IMM2   | second IMM cycle, register file captures bus
  // MWAIT  | memory request outstanding, waiting for ack or timeout
  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_IMM2, S_MWAIT} state_t;

  localparam int IW = OPC_W + OPR_W;
  localparam int TW = $clog2(TIMEOUT + 1);

  state_t            state, state_nxt;
  logic [IW-1:0]     ir;
  logic [TW-1:0]     timer;
  logic [OPC_W-1:0]  op;
  logic [OPR_W-1:0]  opnd;
  logic [1:0]        d;
  logic              is_alu, is_mem, instr_mem, accept, timer_tc;
  logic [DATA_W-1:0] bus_val;

  assign op        = ir[IW-1 -: OPC_W];
  assign opnd      = ir[OPR_W-1:0];
  assign d         = op[1:0];
  assign is_alu    = ~op[OPC_W-1];
  assign is_mem    = op[OPC_W-1] & op[OPC_W-2];
  assign instr_mem = instr[IW-1] & instr[IW-2];
  assign accept    = (state == S_IDLE) && instr_valid;
  assign timer_tc  = (timer == '0);
  assign bus_val   = DATA_W'(opnd);

  assign bus = bus_oe ? bus_val : {DATA_W{1'bz}};

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      ir    <= '0;
      timer <= '0;
    end else begin
      state <= state_nxt;
      if (accept) ir <= instr;
      // down-counter loaded on entry to MWAIT; holds at zero rather than wrapping
      if (accept && instr_mem) timer <= TW'(TIMEOUT - 1);
      else if (state == S_MWAIT && !timer_tc) timer <= timer - TW'(1);
    end
  end

  always_comb begin
    state_nxt   = state;
    instr_ready = 1'b0;
    bus_oe      = 1'b0;
    instr_r     = '0;
    instr_a     = '0;
    reg_we      = 1'b0;
    reg_oe      = 1'b0;
    alu_en      = 1'b0;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = '0;
    done        = 1'b0;
    err         = 1'b0;
    case (state)
      S_IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) state_nxt = instr_mem ? S_MWAIT : S_EXEC;
      end
      S_EXEC: begin
        if (is_alu) begin
          alu_en    = 1'b1;
          reg_we    = 1'b1;
          instr_a   = CTRL_W'(op);
          instr_r   = CTRL_W'(opnd);
          done      = 1'b1;
          state_nxt = S_IDLE;
        end else if (!is_mem) begin
          bus_oe    = 1'b1;
          state_nxt = S_IMM2;
        end else begin
          state_nxt = S_IDLE;
        end
      end
      S_IMM2: begin
        bus_oe    = 1'b1;
        reg_we    = 1'b1;
        instr_r   = CTRL_W'(d);
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      S_MWAIT: begin
        mem_req  = 1'b1;
        mem_addr = opnd;
        mem_we   = d[0];
        instr_r  = CTRL_W'(d);
        reg_oe   = d[0];
        // an ack on the last allowed cycle still counts as success
        if (mem_ack) begin
          done      = 1'b1;
          reg_we    = ~d[0];
          state_nxt = S_IDLE;
        end else if (timer_tc) begin
          done      = 1'b1;
          err       = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_useq_ctrl.sv
// Bench for useq_ctrl: directed literal scenarios plus randomized traffic, all checked
// every cycle against an instruction-level model (class + cycle offset since accept).
module tb_useq_ctrl;
  localparam int DATA_W  = 4;
  localparam int OPC_W   = 4;
  localparam int OPR_W   = 4;
  localparam int CTRL_W  = 4;
  localparam int TIMEOUT = 8;

  logic              clk = 1'b0;
  logic              rst, instr_valid, mem_ack;
  logic [7:0]        instr;
  wire  [DATA_W-1:0] bus;
  logic              instr_ready, bus_oe, reg_we, reg_oe, alu_en, mem_req, mem_we, done, err;
  logic [CTRL_W-1:0] instr_r, instr_a;
  logic [OPR_W-1:0]  mem_addr;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  useq_ctrl #(.DATA_W(DATA_W), .OPC_W(OPC_W), .OPR_W(OPR_W), .CTRL_W(CTRL_W),
              .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .instr(instr), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .mem_ack(mem_ack), .bus(bus), .bus_oe(bus_oe),
    .instr_r(instr_r), .instr_a(instr_a), .reg_we(reg_we), .reg_oe(reg_oe),
    .alu_en(alu_en), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .done(done), .err(err)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // model: is an instruction in flight, which one, and how many cycles since accept
  bit       m_busy = 1'b0;
  logic [7:0] m_ir = 8'h00;
  int       m_k = 0;

  always @(negedge clk) begin
    int e_ready, e_oe, e_bus, e_r, e_a, e_we, e_roe, e_alu, e_req, e_mwe, e_addr, e_done, e_err;
    int op, opnd, dd;
    e_ready = 0; e_oe = 0; e_bus = 0; e_r = 0; e_a = 0; e_we = 0; e_roe = 0;
    e_alu = 0; e_req = 0; e_mwe = 0; e_addr = 0; e_done = 0; e_err = 0;
    op   = int'(m_ir) / 16;
    opnd = int'(m_ir) % 16;
    dd   = op % 4;
    if (!m_busy) begin
      e_ready = 1;
    end else if (op < 8) begin
      e_alu = 1; e_we = 1; e_a = op; e_r = opnd; e_done = 1;
    end else if (op < 12) begin
      e_oe = 1; e_bus = opnd;
      if (m_k == 2) begin
        e_we = 1; e_r = dd; e_done = 1;
      end
    end else begin
      e_req = 1; e_addr = opnd; e_mwe = dd % 2; e_r = dd; e_roe = dd % 2;
      if (mem_ack === 1'b1) begin
        e_done = 1; e_we = 1 - (dd % 2);
      end else if (m_k == TIMEOUT) begin
        e_done = 1; e_err = 1;
      end
    end
    if (chk_en) begin
      check("instr_ready", int'(instr_ready), e_ready);
      check("bus_oe", int'(bus_oe), e_oe);
      if (e_oe != 0) check("bus", int'(bus), e_bus);
      check("instr_r", int'(instr_r), e_r);
      check("instr_a", int'(instr_a), e_a);
      check("reg_we", int'(reg_we), e_we);
      check("reg_oe", int'(reg_oe), e_roe);
      check("alu_en", int'(alu_en), e_alu);
      check("mem_req", int'(mem_req), e_req);
      if (e_req != 0) begin
        check("mem_we", int'(mem_we), e_mwe);
        check("mem_addr", int'(mem_addr), e_addr);
      end
      check("done", int'(done), e_done);
      check("err", int'(err), e_err);
    end
    if (rst === 1'b1) m_busy = 1'b0;
    else if (!m_busy) begin
      if (instr_valid === 1'b1) begin
        m_busy = 1'b1; m_ir = instr; m_k = 1;
      end
    end else if (e_done != 0) m_busy = 1'b0;
    else m_k++;
  end

  initial begin
    int cnt_alu, cnt_rdy, cnt_req;
    rst = 1'b1; instr_valid = 1'b0; mem_ack = 1'b0; instr = 8'h00;
    tick; tick;
    rst = 1'b0; chk_en = 1'b1;
    @(negedge clk);
    check("rst_ready", int'(instr_ready), 1);
    check("rst_bus_oe", int'(bus_oe), 0);
    check("rst_done", int'(done), 0);
    check("rst_mem_req", int'(mem_req), 0);

    // ALU/REG
    tick; instr = 8'h35; instr_valid = 1'b1;
    tick; instr_valid = 1'b0;
    @(negedge clk);
    check("alu_alu_en", int'(alu_en), 1);
    check("alu_instr_a", int'(instr_a), 3);
    check("alu_instr_r", int'(instr_r), 5);
    check("alu_done", int'(done), 1);

    // IMM
    tick; instr = 8'hA9; instr_valid = 1'b1;
    tick; instr_valid = 1'b0;
    @(negedge clk);
    check("imm1_bus", int'(bus), 9);
    check("imm1_done", int'(done), 0);
    tick;
    @(negedge clk);
    check("imm2_reg_we", int'(reg_we), 1);
    check("imm2_instr_r", int'(instr_r), 2);
    check("imm2_done", int'(done), 1);

    // load, ack on third MWAIT cycle
    tick; instr = 8'hC6; instr_valid = 1'b1;
    tick; instr_valid = 1'b0;
    @(negedge clk);
    check("ld_mem_addr", int'(mem_addr), 6);
    check("ld_mem_we", int'(mem_we), 0);
    tick; tick; mem_ack = 1'b1;
    @(negedge clk);
    check("ld_done", int'(done), 1);
    check("ld_reg_we", int'(reg_we), 1);
    check("ld_err", int'(err), 0);
    tick; mem_ack = 1'b0;
    @(negedge clk);
    check("ld_req_drop", int'(mem_req), 0);

    // store with timeout
    tick; instr = 8'hD1; instr_valid = 1'b1;
    tick; instr_valid = 1'b0;
    cnt_req = 0;
    for (int k = 1; k <= TIMEOUT; k++) begin
      @(negedge clk);
      cnt_req += int'(mem_req);
      if (k == TIMEOUT) begin
        check("st_to_done", int'(done), 1);
        check("st_to_err", int'(err), 1);
        check("st_to_reg_we", int'(reg_we), 0);
      end
      tick;
    end
    @(negedge clk);
    check("st_req_cycles", cnt_req, 8);
    check("st_req_drop", int'(mem_req), 0);

    // reset in the middle of IMM
    tick; instr = 8'hA9; instr_valid = 1'b1;
    tick; instr_valid = 1'b0; rst = 1'b1;
    tick; rst = 1'b0;
    @(negedge clk);
    check("rstmid_ready", int'(instr_ready), 1);
    check("rstmid_bus_oe", int'(bus_oe), 0);

    // valid held high, stray ack in idle
    tick; instr = 8'h35; instr_valid = 1'b1; mem_ack = 1'b1;
    cnt_alu = 0; cnt_rdy = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      cnt_alu += int'(alu_en);
      cnt_rdy += int'(instr_ready);
      tick;
    end
    instr_valid = 1'b0; mem_ack = 1'b0;
    check("hold_alu_count", cnt_alu, 3);
    check("hold_ready_count", cnt_rdy, 3);

    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      tick;
      rst         = ($urandom_range(0, 149) == 0);
      instr_valid = ($urandom_range(0, 2) != 0);
      instr       = 8'($urandom);
      mem_ack     = ($urandom_range(0, 5) == 0);
    end
    tick;
    rst = 1'b0; instr_valid = 1'b0; mem_ack = 1'b0;
    for (int i = 0; i < TIMEOUT + 4; i++) tick;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
